// File: rtl/bicubic_channel_arbiter.sv
// bicubic_channel_arbiter: round-robin quantum arbiter sharing one bicubic core among colour channels,
// with an in-order tag FIFO that routes core results back to the channel that issued each window.
module bicubic_channel_arbiter #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int NUM_CH = 3,
  parameter int BLOCK_SIZE = 960,
  parameter int ROWS_PER_QUANTUM = 4,
  parameter int TAG_DEPTH = 8,
  localparam int GW = $clog2(NUM_CH),
  localparam int WW = 16*CHANNEL_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_req_valid,
  output logic [NUM_CH-1:0]          ch_req_ready,
  input  logic [NUM_CH*WW-1:0]       ch_req_win,
  output logic                       bf_req_valid,
  input  logic                       bcci_req_ready,
  output logic [WW-1:0]              core_win,
  input  logic                       bcci_rsp_valid,
  input  logic [4*CHANNEL_WIDTH-1:0] bcci_rsp_data,
  output logic                       bf_rsp_ready,
  output logic [NUM_CH-1:0]          ch_rsp_valid,
  input  logic [NUM_CH-1:0]          ch_rsp_ready,
  output logic [4*CHANNEL_WIDTH-1:0] ch_rsp_data,
  output logic [GW-1:0]              grant_id,
  output logic                       busy,
  output logic                       err_orphan
);
  localparam int QB = ROWS_PER_QUANTUM*(BLOCK_SIZE+1);
  localparam int BW = $clog2(QB);
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int OW = $clog2(TAG_DEPTH)+1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic [GW-1:0] r_grant, r_last, w_pick, w_head;
  logic [BW-1:0] r_beat;
  logic [AW-1:0] r_wp, r_rp;
  logic [OW-1:0] r_cnt;
  logic [GW-1:0] r_tags [TAG_DEPTH];
  logic r_orphan, w_full, w_empty, w_push, w_pop, w_last;
  assign w_full       = r_cnt == OW'(TAG_DEPTH);
  assign w_empty      = r_cnt == '0;
  assign w_head       = r_tags[r_rp];
  assign w_last       = r_beat == BW'(QB-1);
  assign busy         = r_state == BUSY;
  assign grant_id     = r_grant;
  assign err_orphan   = r_orphan;
  assign core_win     = ch_req_win[r_grant*WW +: WW];
  assign bf_req_valid = busy & ch_req_valid[r_grant] & ~w_full;
  assign ch_req_ready = (busy & bcci_req_ready & ~w_full) ? NUM_CH'(1) << r_grant : '0;
  // Core ties its req_ready to rsp_ready, so keep accepting while nothing is owed.
  assign bf_rsp_ready = w_empty ? 1'b1 : ch_rsp_ready[w_head];
  assign ch_rsp_valid = (bcci_rsp_valid & ~w_empty) ? NUM_CH'(1) << w_head : '0;
  assign ch_rsp_data  = bcci_rsp_data;
  assign w_push       = bf_req_valid & bcci_req_ready;
  assign w_pop        = bcci_rsp_valid & bf_rsp_ready & ~w_empty;
  // Lowest offset after last_grant wins, so iterate from the far end down.
  always_comb begin
    w_pick = r_last;
    for (int i = NUM_CH; i >= 1; i--)
      if (ch_req_valid[GW'((int'(r_last) + i) % NUM_CH)]) w_pick = GW'((int'(r_last) + i) % NUM_CH);
  end
  always_comb
    w_next = (r_state == IDLE) ? (|ch_req_valid ? BUSY : IDLE) : ((w_push && w_last) ? IDLE : BUSY);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant  <= '0;
      r_last   <= GW'(NUM_CH-1);
      r_beat   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (r_state == IDLE && |ch_req_valid) r_grant <= w_pick;
      if (w_push) begin
        r_wp   <= (r_wp == AW'(TAG_DEPTH-1)) ? '0 : r_wp + 1'b1;
        r_beat <= w_last ? '0 : r_beat + 1'b1;
        if (w_last) r_last <= r_grant;
      end
      if (w_pop) r_rp <= (r_rp == AW'(TAG_DEPTH-1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + OW'(w_push) - OW'(w_pop);
      if (bcci_rsp_valid && w_empty) r_orphan <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_tags[r_wp] <= r_grant;
endmodule
